// File: rtl/mc_fifo_pkg.sv
// rtl/mc_fifo_pkg.sv - shared entry-count encoding and burst-position sizing
package mc_fifo_pkg;

  localparam int unsigned CNT_BITS = 2;

  typedef logic [CNT_BITS-1:0] cnt_t;

  localparam cnt_t CNT_EMPTY = 2'd0;
  localparam cnt_t CNT_MAX   = 2'd2;

  // A one-beat burst still needs a 1-bit position register.
  function automatic int pos_width(input int burst_len);
    return (burst_len <= 1) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/afifo_rd_skid.sv
// rtl/afifo_rd_skid.sv - two-entry output buffer with head/tail registers
module afifo_rd_skid
  import mc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output cnt_t                  cnt,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] tail;

  // clear only drops occupancy; head keeps its value so m_data does not glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= CNT_EMPTY;
      head <= '0;
      tail <= '0;
    end else if (clear) begin
      cnt <= CNT_EMPTY;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == CNT_EMPTY) head <= push_data;
          else                  tail <= push_data;
          cnt <= cnt + 1'b1;
        end
        2'b01: begin
          if (cnt == CNT_MAX) head <= tail;
          cnt <= cnt - 1'b1;
        end
        2'b11: begin
          if (cnt == CNT_MAX) begin
            head <= tail;
            tail <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/afifo_rd_stream.sv
// rtl/afifo_rd_stream.sv - async FIFO read-side consumer with registered framed stream
module afifo_rd_stream
  import mc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  localparam int PW = pos_width(BURST_LEN);
  localparam logic [PW-1:0] POS_LAST = PW'(BURST_LEN - 1);

  cnt_t          cnt;
  logic          inflight;
  logic [PW-1:0] pos;
  logic          xfer;
  logic [2:0]    pending;

  assign m_valid = ~rst & (cnt != CNT_EMPTY);
  assign xfer    = m_valid & m_ready;
  assign m_last  = m_valid & (pos == POS_LAST);

  // Entries that will occupy the buffer after this edge, counting the one in flight.
  assign pending    = {1'b0, cnt} + {2'b00, inflight} - {2'b00, xfer};
  assign fifo_rd_en = ~rst & ~flush & ~fifo_empty & (pending < 3'd2);

  afifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (inflight),
    .push_data (fifo_rd_data),
    .pop       (xfer),
    .cnt       (cnt),
    .head      (m_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      pos      <= '0;
      beat_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (flush)                  pos <= '0;
      else if (xfer && pos == POS_LAST) pos <= '0;
      else if (xfer)              pos <= pos + 1'b1;
      if (xfer) beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_afifo_rd_stream.sv
// tb/tb_afifo_rd_stream.sv - self-checking bench for afifo_rd_stream
module tb_afifo_rd_stream;

  localparam int DATA_WIDTH = 4;
  localparam int BURST_LEN  = 4;
  localparam int CNT_WIDTH  = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  flush = 1'b0;
  logic                  fifo_empty = 1'b1;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data = '0;
  logic                  m_valid;
  logic                  m_ready = 1'b0;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic [CNT_WIDTH-1:0]  beat_cnt;

  afifo_rd_stream #(
    .DATA_WIDTH(DATA_WIDTH),
    .BURST_LEN (BURST_LEN),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .beat_cnt     (beat_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Source FIFO: registered empty flag, data returned the cycle after a pop.
  logic [DATA_WIDTH-1:0] q[$];
  // Reference model: values popped but not yet delivered, with the cycle of the pop.
  logic [DATA_WIDTH-1:0] sb[$];
  int                    sb_t[$];
  int                    cyc  = 0;
  int                    pops = 0;
  logic [CNT_WIDTH-1:0]  exp_beats = '0;
  int                    exp_pos = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en) begin
        if (q.size() == 0) begin
          check("pop_while_source_empty", 32'd1, 32'd0);
        end else begin
          fifo_rd_data <= q[0];
          sb.push_back(q[0]);
          sb_t.push_back(cyc);
          void'(q.pop_front());
          pops++;
        end
      end
      fifo_empty <= (q.size() == 0);
    end
  end

  always @(negedge clk) begin
    logic exp_valid;
    int   occ_after;
    exp_valid = !rst && sb.size() != 0 && sb_t[0] < cyc;
    occ_after = sb.size() - ((exp_valid && m_ready) ? 1 : 0);
    check("m_valid", m_valid, exp_valid);
    check("fifo_rd_en", fifo_rd_en, !rst && !flush && !fifo_empty && occ_after < 2);
    check("occupancy_le_2", sb.size() <= 2, 1);
    check("m_last", m_last, exp_valid && exp_pos == BURST_LEN - 1);
    check("beat_cnt", beat_cnt, exp_beats);
    if (exp_valid && m_ready) begin
      check("m_data", m_data, sb[0]);
      void'(sb.pop_front());
      void'(sb_t.pop_front());
      exp_beats++;
      exp_pos = (exp_pos + 1) % BURST_LEN;
    end
    if (rst || flush) begin
      sb.delete();
      sb_t.delete();
      exp_pos = 0;
      if (rst) exp_beats = '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && (q.size() != 0 || sb.size() != 0); i++) tick();
    check(tag, q.size() + sb.size(), 0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!m_valid && n < 40) begin
      tick();
      n++;
    end
    check(tag, m_valid, 1);
  endtask

  initial begin
    int p0;
    logic [CNT_WIDTH-1:0] bc;

    tick();
    check("reset_m_valid", m_valid, 0);
    check("reset_m_last", m_last, 0);
    check("reset_rd_en", fifo_rd_en, 0);
    check("reset_beat_cnt", beat_cnt, 0);
    check("reset_m_data", m_data, 0);
    rst = 1'b0;
    tick();

    // Single entry: pop one cycle, data valid two cycles later.
    m_ready = 1'b1;
    q.push_back(4'hA);
    tick();
    check("single_rd_en", fifo_rd_en, 1);
    tick();
    check("single_rd_en_once", fifo_rd_en, 0);
    check("single_not_yet_valid", m_valid, 0);
    tick();
    check("single_valid", m_valid, 1);
    check("single_data", m_data, 4'hA);
    tick();
    check("single_beat_cnt", beat_cnt, 1);

    // Eight entries, sustained one beat per cycle.
    do_reset();
    for (int i = 0; i < 8; i++) q.push_back(DATA_WIDTH'(i));
    repeat (11) tick();
    check("stream8_no_bubbles", beat_cnt, 8);

    // Backpressure: only two pops while stalled, head held.
    do_reset();
    m_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 8; i++) q.push_back(DATA_WIDTH'(i));
    repeat (5) tick();
    check("stall_pops", pops - p0, 2);
    check("stall_valid", m_valid, 1);
    check("stall_data_held", m_data, 0);
    m_ready = 1'b1;
    drain("stall_drain");
    check("stall_beat_cnt", beat_cnt, 8);

    // Ready toggling every cycle.
    do_reset();
    for (int i = 0; i < 6; i++) q.push_back(DATA_WIDTH'(i));
    for (int i = 0; i < 60 && (q.size() != 0 || sb.size() != 0); i++) begin
      m_ready = ~m_ready;
      tick();
    end
    check("toggle_beat_cnt", beat_cnt, 6);
    m_ready = 1'b1;

    // Flush with one buffered and one in-flight entry.
    do_reset();
    m_ready = 1'b0;
    q.push_back(4'h5);
    q.push_back(4'h6);
    wait_valid("flush_setup_valid");
    bc = beat_cnt;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_drops_valid", m_valid, 0);
    check("flush_keeps_beat_cnt", beat_cnt, bc);
    q.push_back(4'h3);
    m_ready = 1'b1;
    wait_valid("flush_refill_valid");
    check("flush_next_data", m_data, 4'h3);
    check("flush_pos_restart", m_last, 0);
    drain("flush_drain");
    check("flush_beat_cnt", beat_cnt, bc + 1'b1);

    // Reset mid-burst at position 2.
    do_reset();
    for (int i = 0; i < 10; i++) q.push_back(DATA_WIDTH'(i + 3));
    for (int i = 0; i < 40 && beat_cnt != 2; i++) tick();
    check("midburst_reached", beat_cnt, 2);
    rst = 1'b1;
    tick();
    check("midburst_valid", m_valid, 0);
    check("midburst_beat_cnt", beat_cnt, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) q.push_back(DATA_WIDTH'(i + 9));
    drain("midburst_drain");
    check("midburst_after", beat_cnt, 4);

    // Random traffic, backpressure and flushes against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(1, 0) == 1 && q.size() < 16) q.push_back(DATA_WIDTH'($urandom));
      m_ready = ($urandom_range(3, 0) != 0);
      flush   = ($urandom_range(31, 0) == 0);
      tick();
    end
    flush   = 1'b0;
    m_ready = 1'b1;
    drain("random_drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
